// File: rtl/present_pkg.sv
// Shared types, S-box/P-layer helpers and parameter checks for the PRESENT cipher core.
package present_pkg;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  // Nibble at index 0 is the leftmost hex digit
  localparam logic [63:0] SBOX     = 64'hC56B90AD3EF84712;
  localparam logic [63:0] INV_SBOX = 64'h5EF8C12DB463079A;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{~x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{~x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox64(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] inv_sbox64(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv_sbox4(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] player(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[(16*i) % 63] = x[i];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [63:0] inv_player(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[i] = x[(16*i) % 63];
    r[63] = x[63];
    return r;
  endfunction

  function automatic bit key_width_ok(input int w);
    return (w == 80) || (w == 128);
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// Combinational PRESENT key schedule step: forward update or its exact inverse.
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80
) (
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [4:0]           rc,
  input  logic                 dir,
  output logic [KEY_WIDTH-1:0] key_next,
  output logic [63:0]          round_key
);

  localparam int RC_LSB = (KEY_WIDTH == 128) ? 62 : 15;

  logic [KEY_WIDTH-1:0] fwd;
  logic [KEY_WIDTH-1:0] tmp;
  logic [KEY_WIDTH-1:0] inv;

  assign round_key = key[KEY_WIDTH-1 -: 64];

  always_comb begin
    fwd = {key[KEY_WIDTH-62:0], key[KEY_WIDTH-1:KEY_WIDTH-61]};
    fwd[KEY_WIDTH-1 -: 4] = sbox4(fwd[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) fwd[KEY_WIDTH-5 -: 4] = sbox4(fwd[KEY_WIDTH-5 -: 4]);
    fwd[RC_LSB +: 5] = fwd[RC_LSB +: 5] ^ rc;

    // Inverse undoes the three forward steps in reverse order
    tmp = key;
    tmp[RC_LSB +: 5] = tmp[RC_LSB +: 5] ^ rc;
    tmp[KEY_WIDTH-1 -: 4] = inv_sbox4(tmp[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) tmp[KEY_WIDTH-5 -: 4] = inv_sbox4(tmp[KEY_WIDTH-5 -: 4]);
    inv = {tmp[60:0], tmp[KEY_WIDTH-1:61]};

    key_next = dir ? inv : fwd;
  end

endmodule

// File: rtl/present_cipher_core.sv
// Iterative PRESENT encrypt/decrypt engine with valid/ready handshakes.
// Optional last-key cache for decryption enabled by defining PRESENT_KEY_CACHE_EN.
module present_cipher_core
  import present_pkg::*;
#(
  parameter int KEY_WIDTH = 80,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 iReset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [63:0]          in_data,
  input  logic [KEY_WIDTH-1:0] in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic                 busy
);

  if (!key_width_ok(KEY_WIDTH)) begin : g_bad_key_width
    $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_cipher_core: ROUNDS must be in 1..31");
  end

  localparam logic [4:0] RC_LAST = 5'(ROUNDS);

  state_t               state_q;
  logic [63:0]          data_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [4:0]           rc_q;
  logic                 dec_q;

  logic [KEY_WIDTH-1:0] ks_next;
  logic [63:0]          rk;
  logic [63:0]          next_rk;
  logic [63:0]          enc_state;
  logic [63:0]          dec_state;
  logic                 cache_hit;
  logic [KEY_WIDTH-1:0] cache_last;

  present_key_sched #(.KEY_WIDTH(KEY_WIDTH)) u_key_sched (
    .key       (key_q),
    .rc        (rc_q),
    .dir       (dec_q && (state_q == ROUND)),
    .key_next  (ks_next),
    .round_key (rk)
  );

  assign next_rk   = ks_next[KEY_WIDTH-1 -: 64];
  assign enc_state = player(sbox64(data_q ^ rk));
  assign dec_state = inv_sbox64(inv_player(data_q)) ^ next_rk;

  assign in_ready = (state_q == IDLE) && !iReset;
  assign busy     = (state_q != IDLE);

`ifdef PRESENT_KEY_CACHE_EN
  logic [KEY_WIDTH-1:0] orig_key_q;
  logic [KEY_WIDTH-1:0] cache_key_q;
  logic [KEY_WIDTH-1:0] cache_last_q;
  logic                 cache_key_vld_q;
  logic                 cache_last_vld_q;

  assign cache_hit  = cache_key_vld_q && cache_last_vld_q && (in_key == cache_key_q);
  assign cache_last = cache_last_q;

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      orig_key_q       <= '0;
      cache_key_q      <= '0;
      cache_last_q     <= '0;
      cache_key_vld_q  <= 1'b0;
      cache_last_vld_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid && mode) orig_key_q <= in_key;
      if (state_q == KEYEXP && rc_q == RC_LAST) begin
        cache_key_q      <= orig_key_q;
        cache_last_q     <= ks_next;
        cache_key_vld_q  <= 1'b1;
        cache_last_vld_q <= 1'b1;
      end
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_last = '0;
`endif

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      key_q     <= '0;
      rc_q      <= '0;
      dec_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rc_q  <= 5'd1;
            dec_q <= mode;
            if (!mode) begin
              data_q  <= in_data;
              key_q   <= in_key;
              state_q <= ROUND;
            end else if (cache_hit) begin
              data_q  <= in_data ^ cache_last[KEY_WIDTH-1 -: 64];
              key_q   <= cache_last;
              rc_q    <= RC_LAST;
              state_q <= ROUND;
            end else begin
              data_q  <= in_data;
              key_q   <= in_key;
              state_q <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          key_q <= ks_next;
          if (rc_q == RC_LAST) begin
            data_q  <= data_q ^ next_rk;
            state_q <= ROUND;
          end else begin
            rc_q <= rc_q + 5'd1;
          end
        end
        ROUND: begin
          key_q <= ks_next;
          if (!dec_q) begin
            // Final encrypt round also folds in the post-whitening key
            if (rc_q == RC_LAST) begin
              data_q    <= enc_state ^ next_rk;
              out_data  <= enc_state ^ next_rk;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              data_q <= enc_state;
              rc_q   <= rc_q + 5'd1;
            end
          end else begin
            data_q <= dec_state;
            if (rc_q == 5'd1) begin
              out_data  <= dec_state;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end else begin
              rc_q <= rc_q - 5'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_cipher_core.sv
// Directed-vector bench for present_cipher_core with 80- and 128-bit key instances.
module tb_present_cipher_core;

`ifdef PRESENT_KEY_CACHE_EN
  localparam int HIT_LAT = 31;
`else
  localparam int HIT_LAT = 62;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid80, in_valid128;
  logic         mode;
  logic [63:0]  in_data;
  logic [127:0] in_key128;
  logic         out_ready;

  logic         ir80, ov80, busy80;
  logic [63:0]  od80;
  logic         ir128, ov128, busy128;
  logic [63:0]  od128;

  int passed = 0;
  int total  = 0;

  present_cipher_core #(.KEY_WIDTH(80), .ROUNDS(31)) dut80 (
    .clk       (clk),
    .iReset    (rst),
    .in_valid  (in_valid80),
    .in_ready  (ir80),
    .mode      (mode),
    .in_data   (in_data),
    .in_key    (in_key128[79:0]),
    .out_valid (ov80),
    .out_ready (out_ready),
    .out_data  (od80),
    .busy      (busy80)
  );

  present_cipher_core #(.KEY_WIDTH(128), .ROUNDS(31)) dut128 (
    .clk       (clk),
    .iReset    (rst),
    .in_valid  (in_valid128),
    .in_ready  (ir128),
    .mode      (mode),
    .in_data   (in_data),
    .in_key    (in_key128),
    .out_valid (ov128),
    .out_ready (out_ready),
    .out_data  (od128),
    .busy      (busy128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: accept, wait for result (bounded), optionally stall, then take it
  task automatic op(input string tag, input bit w128, input bit m, input logic [63:0] d,
                    input logic [127:0] k, input bit early, input int hold,
                    input logic [63:0] exp_res, input int exp_lat);
    logic [63:0] res;
    int lat;
    mode = m;
    in_data = d;
    in_key128 = k;
    out_ready = early;
    check({tag, "_in_ready"}, w128 ? ir128 : ir80, 1'b1);
    if (w128) in_valid128 = 1'b1;
    else      in_valid80  = 1'b1;
    @(posedge clk); #1;
    in_valid80  = 1'b0;
    in_valid128 = 1'b0;
    lat = 0;
    while (!(w128 ? ov128 : ov80) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = w128 ? od128 : od80;
    check({tag, "_data"}, res, exp_res);
    check({tag, "_latency"}, lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_data"}, w128 ? od128 : od80, res);
      check({tag, "_hold_in_ready"}, w128 ? ir128 : ir80, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_taken"}, w128 ? ov128 : ov80, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid80 = 1'b0;
    in_valid128 = 1'b0;
    mode = 1'b0;
    in_data = '0;
    in_key128 = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", ov80, 1'b0);
    check("rst_out_data", od80, 64'h0);
    check("rst_busy", busy80, 1'b0);
    check("rst_in_ready", ir80, 1'b0);
    check("rst_in_ready128", ir128, 1'b0);
    check("rst_out_data128", od128, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    op("enc80_zero", 1'b0, 1'b0, 64'h0, 128'h0, 1'b0, 0, 64'h5579C1387B228445, 31);
    op("enc80_kff",  1'b0, 1'b0, 64'h0, 128'hFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 0,
       64'hE72C46C0F5945049, 31);
    op("enc80_ff",   1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 128'hFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 0,
       64'h3333DCD3213210D2, 31);
    op("dec80_ff",   1'b0, 1'b1, 64'h3333DCD3213210D2, 128'hFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 0,
       64'hFFFFFFFFFFFFFFFF, 62);
    op("dec80_ff2",  1'b0, 1'b1, 64'h3333DCD3213210D2, 128'hFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 0,
       64'hFFFFFFFFFFFFFFFF, HIT_LAT);
    op("dec80_zero", 1'b0, 1'b1, 64'h5579C1387B228445, 128'h0, 1'b0, 0, 64'h0, 62);
    op("enc128_zero", 1'b1, 1'b0, 64'h0, 128'h0, 1'b0, 0, 64'h96DB702A2E6900AF, 31);
    op("dec128_zero", 1'b1, 1'b1, 64'h96DB702A2E6900AF, 128'h0, 1'b0, 0, 64'h0, 62);
    op("hold80", 1'b0, 1'b0, 64'h0, 128'h0, 1'b0, 10, 64'h5579C1387B228445, 31);

    // Abort an encryption in the middle of its rounds
    mode = 1'b0;
    in_data = 64'h0;
    in_key128 = 128'h0;
    in_valid80 = 1'b1;
    @(posedge clk); #1;
    in_valid80 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("mid_busy", busy80, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", ov80, 1'b0);
    check("abort_busy", busy80, 1'b0);
    check("abort_in_ready", ir80, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op("dec80_after_rst", 1'b0, 1'b1, 64'h3333DCD3213210D2, 128'hFFFF_FFFFFFFF_FFFFFFFF, 1'b0, 0,
       64'hFFFFFFFFFFFFFFFF, 62);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/present_cipher_core.md
# present_cipher_core

Parametrised, iterative PRESENT block cipher engine with a valid/ready handshake on both sides. It supports 80- and 128-bit keys, encryption and decryption, and a configurable round count. It is the successor core for the PRESENT peripheral and is instantiated behind the bus register wrapper. Round logic and key schedule are built in, not split across separate encrypt and decrypt instances.

## Interface
- KEY_WIDTH, 80, key size; legal values 80 or 128 only, anything else is a synthesis error.
- ROUNDS, 31, cipher rounds; legal range 1..31; 31 is standard PRESENT.
- clk  in  1  clock; all logic on rising edge.
- iReset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  core accepts a request; high only in IDLE with iReset low.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- in_data  in  64  plaintext or ciphertext; sampled on accept.
- in_key  in  KEY_WIDTH  cipher key; sampled on accept.
- out_valid  out  1  result available; held until taken.
- out_ready  in  1  consumer takes the result.
- out_data  out  64  result; stable while out_valid is high.
- busy  out  1  high in KEYEXP, ROUND or DONE.

## Operation
- States: IDLE, KEYEXP, ROUND, DONE.
- Accept: an edge with in_valid && in_ready.
  - Registers data, key and mode, and loads round counter rc = 1.
  - Encrypt goes to ROUND.
  - Decrypt goes to KEYEXP.
- Encrypt ROUND step, with round key = top 64 bits of the key register:
  - state ← P(S(state ^ K)).
  - Key ← update(K, rc).
  - rc increments.
  - The step with rc == ROUNDS also XORs in the next key (K_ROUNDS+1), writes out_data, sets out_valid, and goes to DONE.
- Decrypt KEYEXP:
  - Each cycle applies key update(K, rc) and increments rc.
  - After ROUNDS updates, the register holds K_ROUNDS+1.
  - state ← state ^ K_ROUNDS+1.
  - rc = ROUNDS, then go to ROUND.
- Decrypt ROUND step:
  - K ← inverse_update(K, rc).
  - state ← S⁻¹(P⁻¹(state)) ^ K.
  - rc decrements.
  - The step with rc == 1 writes out_data, sets out_valid, and goes to DONE.
- Key update, 80-bit:
  - Rotate left 61.
  - S-box on [79:76].
  - [19:15] ^= rc.
- Key update, 128-bit:
  - Rotate left 61.
  - S-box on [127:124] and on [123:120].
  - [66:62] ^= rc.
- Inverse key update: exact reverse order (XOR rc, inverse S-box, rotate right 61).
- S-box is C56B90AD3EF84712 (index 0 is the leftmost digit).
- P-layer: bit i moves to (16·i) mod 63 for i < 63; bit 63 stays fixed.
- DONE: an edge with out_ready clears out_valid and returns to IDLE. in_ready is not high in DONE.
- rc is 5 bits and never wraps; ROUNDS ≤ 31 guarantees this.

## Timing
- Reset values: out_valid 0, out_data 0, busy 0, in_ready 0 while iReset is high, state IDLE.
- Encrypt latency: out_valid rises ROUNDS cycles after the accept edge.
- Decrypt latency: 2·ROUNDS cycles, or ROUNDS cycles on a key-cache hit.
- Throughput: one request per latency + 2 cycles (accept, compute, DONE handshake, IDLE).
- If out_ready is already high when out_valid rises, the result is taken on the next edge.
- in_valid, mode, in_data and in_key are ignored while in_ready is low; no buffering.
- iReset mid-operation aborts immediately:
  - The result is discarded and out_valid drops.
  - The key cache is invalidated.
  - After release the core restarts in IDLE.

## Configuration
- PRESENT_KEY_CACHE_EN defined:
  - Stores the last input key and its K_ROUNDS+1, each with a valid bit.
  - A decrypt whose in_key matches the stored key skips KEYEXP: it goes directly to ROUND with the cached key and the initial XOR applied.
  - Every completed KEYEXP refreshes the cache.
  - Encryption never touches the cache.
- PRESENT_KEY_CACHE_EN undefined: every decrypt runs KEYEXP, and no cache registers exist.

## Structure
- present_pkg holds:
  - the state enum;
  - SBOX and INV_SBOX constants;
  - functions sbox64, inv_sbox64, player and inv_player;
  - the KEY_WIDTH legality check.
- Sub-module present_key_sched (combinational, parameter KEY_WIDTH):
  - Inputs: key, rc, dir.
  - Output: the forward or inverse updated key, plus the current round key (top 64 bits).

## Test plan
- KEY_WIDTH=80, encrypt, data 0, key 0 -> out_data 5579C1387B228445, out_valid exactly 31 cycles after accept.
- KEY_WIDTH=80, encrypt with all-ones key, data 0 -> E72C46C0F5945049.
- KEY_WIDTH=80, encrypt with all-ones data and all-ones key -> 3333DCD3213210D2.
- KEY_WIDTH=80, decrypt that ciphertext with the all-ones key -> FFFFFFFFFFFFFFFF after 62 cycles.
  - With PRESENT_KEY_CACHE_EN, a second decrypt with the same key completes in 31 cycles.
  - A different key costs 62 cycles again.
- KEY_WIDTH=128, encrypt, data 0, key 0 -> 96DB702A2E6900AF; decrypt returns 0.
- Handshake and reset:
  - Hold out_ready low for 10 cycles: out_data stays stable and in_ready stays 0.
  - Assert iReset at round 15: out_valid and busy go 0 immediately.
  - A fresh request after release gives the correct result and a cache miss (62 cycles).
